// File: rtl/addr_seq_reader.sv
// addr_seq_reader
//   Burst reader that walks an external address register. A start in IDLE
//   loads the register with src_base. Each byte then takes three phases:
//   ADDR issues the read, WAIT captures the data, and OUT presents the byte
//   until the consumer accepts it. Between bytes the address register is
//   incremented, and DONE clears it when the burst ends.
//
// Ports
//   clk, reset          clock; synchronous active-high reset
//   start               burst request, sampled only in IDLE
//   src_base, count     burst start address and byte count (count 0 = empty)
//   ar_dataout          current value of the external address register
//   ar_write_en/datain  load pulse and load value for the address register
//   ar_inc, ar_reset    increment and clear pulses for the address register
//   mem_addr, mem_rd    memory read address and strobe (data one cycle later)
//   mem_rdata           memory read data
//   out_data/valid      delivered byte with its valid flag
//   out_ready           consumer accept
//   busy, done          not-IDLE flag; one-cycle end-of-burst pulse
module addr_seq_reader (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] src_base,
  input  logic [7:0] count,
  input  logic [7:0] ar_dataout,
  output logic       ar_write_en,
  output logic [7:0] ar_datain,
  output logic       ar_inc,
  output logic       ar_reset,
  output logic [7:0] mem_addr,
  output logic       mem_rd,
  input  logic [7:0] mem_rdata,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_WAIT = 3'd2,
    S_OUT  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t     r_state, w_next;
  logic [7:0] r_remaining;
  logic [7:0] r_out_data;

  logic w_load, w_inc, w_clr, w_rd, w_valid, w_done, w_hs;

  // A byte is accepted only while it is being presented in OUT.
  assign w_hs = (r_state == S_OUT) && out_ready;

  always_comb begin
    w_next  = r_state;
    w_load  = 1'b0;
    w_inc   = 1'b0;
    w_clr   = 1'b0;
    w_rd    = 1'b0;
    w_valid = 1'b0;
    w_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (count != 8'd0) begin
            w_load = 1'b1;
            w_next = S_ADDR;
          end else begin
            w_next = S_DONE;
          end
        end
      end
      S_ADDR: begin
        w_rd   = 1'b1;
        w_next = S_WAIT;
      end
      S_WAIT: w_next = S_OUT;
      S_OUT: begin
        w_valid = 1'b1;
        if (out_ready) begin
          // The <= also covers a zero count, so the burst always ends.
          if (r_remaining <= 8'd1) begin
            w_next = S_DONE;
          end else begin
            w_inc  = 1'b1;
            w_next = S_ADDR;
          end
        end
      end
      S_DONE: begin
        w_done = 1'b1;
        w_clr  = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_remaining <= 8'd0;
      r_out_data  <= 8'd0;
    end else begin
      r_state <= w_next;
      if (w_load)
        r_remaining <= count;
      else if (w_hs)
        r_remaining <= r_remaining - 8'd1;
      if (r_state == S_WAIT)
        r_out_data <= mem_rdata;
    end
  end

  // Outputs are gated by reset so that every strobe is quiet during the
  // reset cycle itself, including the start-driven load pulse in IDLE.
  assign ar_write_en = w_load & ~reset;
  assign ar_datain   = (w_load & ~reset) ? src_base : 8'd0;
  assign ar_inc      = w_inc & ~reset;
  assign ar_reset    = w_clr & ~reset;
  assign mem_rd      = w_rd & ~reset;
  assign out_valid   = w_valid & ~reset;
  assign done        = w_done & ~reset;
  assign busy        = (r_state != S_IDLE) & ~reset;
  assign mem_addr    = ar_dataout;
  assign out_data    = r_out_data;

endmodule
